wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback (WB stage outputs) and a long-latency unit (LU, e.g. multiply/divide) that completes out of band.
- Pipeline writes have priority. LU results are buffered in a small FIFO and drained in cycles where the pipeline does not write.
- Sits between the WB stage / LU and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the WB stage / long-latency unit (master side) and
// the register-file write-port arbiter (slave side).
interface wb_port_arbiter_if #(
  parameter int DEPTH = 4
);
  logic [4:0]             WB_Rd_i;
  logic                   WB_Reg_writeE_i;
  logic [31:0]            WB_Write_data_i;
  logic                   LU_valid_i;
  logic                   LU_ready_o;
  logic [4:0]             LU_Rd_i;
  logic [31:0]            LU_data_i;
  logic                   RF_writeE_o;
  logic [4:0]             RF_Rd_o;
  logic [31:0]            RF_Write_data_o;
  logic                   Pipe_stall_o;
  logic [$clog2(DEPTH):0] Pend_cnt_o;

  modport master (
    output WB_Rd_i, WB_Reg_writeE_i, WB_Write_data_i,
    output LU_valid_i, LU_Rd_i, LU_data_i,
    input  LU_ready_o, RF_writeE_o, RF_Rd_o, RF_Write_data_o,
    input  Pipe_stall_o, Pend_cnt_o
  );

  modport slave (
    input  WB_Rd_i, WB_Reg_writeE_i, WB_Write_data_i,
    input  LU_valid_i, LU_Rd_i, LU_data_i,
    output LU_ready_o, RF_writeE_o, RF_Rd_o, RF_Write_data_o,
    output Pipe_stall_o, Pend_cnt_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, LU results queue in a FIFO.
// Optional starvation relief (forced one-cycle pipeline stall) is enabled by defining WB_ARB_STARVE_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("wb_port_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
  end

  logic [4:0]    rdMem_q   [DEPTH];
  logic [31:0]   dataMem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pipeWr;
  logic          luReady;
  logic          push;
  logic          pop;
  logic          stall;
  logic [4:0]    headRd;
  logic [31:0]   headData;

  assign pipeWr   = bus.WB_Reg_writeE_i && (bus.WB_Rd_i != 5'd0);
  assign luReady  = (count_q < FULL);
  // Results aimed at x0 complete the handshake but are never stored.
  assign push     = bus.LU_valid_i && luReady && (bus.LU_Rd_i != 5'd0);
  assign pop      = (count_q != '0) && (stall || !pipeWr);
  assign headRd   = rdMem_q[rdPtr_q];
  assign headData = dataMem_q[rdPtr_q];

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  assign stall = (count_q != '0) && (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (pop || count_q == '0) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rdMem_q[wrPtr_q]   <= bus.LU_Rd_i;
      dataMem_q[wrPtr_q] <= bus.LU_data_i;
    end
  end

  always_comb begin
    bus.RF_writeE_o     = 1'b0;
    bus.RF_Rd_o         = '0;
    bus.RF_Write_data_o = '0;
    if (!rst_i) begin
      if (pop) begin
        bus.RF_writeE_o     = 1'b1;
        bus.RF_Rd_o         = headRd;
        bus.RF_Write_data_o = headData;
      end else if (pipeWr) begin
        bus.RF_writeE_o     = 1'b1;
        bus.RF_Rd_o         = bus.WB_Rd_i;
        bus.RF_Write_data_o = bus.WB_Write_data_i;
      end
    end
  end

  assign bus.LU_ready_o   = !rst_i && luReady;
  assign bus.Pipe_stall_o = !rst_i && stall;
  assign bus.Pend_cnt_o   = rst_i ? '0 : count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        expWe;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic        expReady;
    int          expPend;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  ent_t mq[$];
  int   waitCnt = 0;
  bit   mPop;
  bit   mPush;
  vec_t vecs[7];
  int   stallCycles;
  int   stallEdge;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.WB_Reg_writeE_i = we;
    bus.WB_Rd_i         = rd;
    bus.WB_Write_data_i = data;
    bus.LU_valid_i      = lv;
    bus.LU_Rd_i         = lrd;
    bus.LU_data_i       = ldata;
  endtask

  // Reference model: pipeline wins unless the queue head has starved; x0 writes are no writes.
  task automatic checkOutput();
    logic        expWe, expStall, expReady, pipeWr;
    logic [4:0]  expRd;
    logic [31:0] expData;
    int          expPend;
    expWe = 1'b0; expRd = '0; expData = '0; expStall = 1'b0; expReady = 1'b0; expPend = 0;
    mPop = 1'b0; mPush = 1'b0;
    if (!rst_i) begin
      pipeWr   = bus.WB_Reg_writeE_i && (bus.WB_Rd_i != 0);
      expStall = STARVE_EN && (mq.size() > 0) && (waitCnt >= STARVE_LIMIT);
      expReady = (mq.size() < DEPTH);
      expPend  = mq.size();
      if (mq.size() > 0 && (expStall || !pipeWr)) begin
        expWe = 1'b1; expRd = mq[0].rd; expData = mq[0].data; mPop = 1'b1;
      end else if (pipeWr) begin
        expWe = 1'b1; expRd = bus.WB_Rd_i; expData = bus.WB_Write_data_i;
      end
      mPush = bus.LU_valid_i && expReady && (bus.LU_Rd_i != 0);
    end
    compare("rf_we",    bus.RF_writeE_o,     expWe);
    compare("rf_rd",    bus.RF_Rd_o,         expRd);
    compare("rf_data",  bus.RF_Write_data_o, expData);
    compare("lu_ready", bus.LU_ready_o,      expReady);
    compare("stall",    bus.Pipe_stall_o,    expStall);
    compare("pend",     bus.Pend_cnt_o,      expPend);
  endtask

  task automatic updateModel();
    int sizeBefore;
    if (rst_i) begin
      mq.delete();
      waitCnt = 0;
    end else begin
      sizeBefore = mq.size();
      if (mPop) void'(mq.pop_front());
      if (mPush) mq.push_back({bus.LU_Rd_i, bus.LU_data_i});
      waitCnt = (mPop || sizeBefore == 0) ? 0 : waitCnt + 1;
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk_i);
    updateModel();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'hAA, 1'b1, 5'd5, 32'h11, 1'b1, 0};
    vecs[1] = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'h11, 1'b1, 1};
    vecs[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hAA, 1'b1, 1};
    vecs[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 0};
    vecs[4] = '{1'b1, 5'd0, 32'h99, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,  1'b1, 0};
    vecs[5] = '{1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h44, 1'b1, 5'd3, 32'h33, 1'b1, 1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 0};

    applyStimulus(1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd4, 32'hBEEF);
    sample();
    compare("reset_ready", bus.LU_ready_o, 1'b0);
    compare("reset_we",    bus.RF_writeE_o, 1'b0);
    advance();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 rst_i = 1'b0;

    // Priority and x0 handling
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      sample();
      compare($sformatf("vec%0d_we", i),    bus.RF_writeE_o,     vecs[i].expWe);
      compare($sformatf("vec%0d_rd", i),    bus.RF_Rd_o,         vecs[i].expRd);
      compare($sformatf("vec%0d_data", i),  bus.RF_Write_data_o, vecs[i].expData);
      compare($sformatf("vec%0d_ready", i), bus.LU_ready_o,      vecs[i].expReady);
      compare($sformatf("vec%0d_pend", i),  bus.Pend_cnt_o,      vecs[i].expPend);
      advance();
    end

    // Full FIFO back-pressure and acceptance order
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'd9, 32'h900 + k, 1'b1, 5'(k), 32'h100 + k);
      tick();
    end
    applyStimulus(1'b1, 5'd9, 32'h999, 1'b1, 5'd5, 32'h105);
    sample();
    compare("full_ready", bus.LU_ready_o, 1'b0);
    compare("full_pend",  bus.Pend_cnt_o, 4);
    advance();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h105);
    sample();
    compare("free_slot_rd",     bus.RF_Rd_o,    5'd1);
    compare("ready_same_cycle", bus.LU_ready_o, 1'b0);
    advance();
    applyStimulus(1'b1, 5'd9, 32'h999, 1'b1, 5'd5, 32'h105);
    sample();
    compare("ready_next_cycle", bus.LU_ready_o, 1'b1);
    compare("pend_after_pop",   bus.Pend_cnt_o, 3);
    advance();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      sample();
      compare("order_rd",   bus.RF_Rd_o,         5'(k));
      compare("order_data", bus.RF_Write_data_o, 32'h100 + k);
      advance();
    end
    tick();

    // Simultaneous push/pop at count 2, wrapping the pointers
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 5'd8, 32'h800, 1'b1, 5'(10 + k), 32'h200 + k);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(12 + k), 32'h300 + k);
      sample();
      compare("pushpop_pend", bus.Pend_cnt_o, 2);
      advance();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick();

    // Asynchronous reset in the middle of a drain
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 5'd9, 32'h900, 1'b1, 5'(k), 32'h400 + k);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h404);
    #2 rst_i = 1'b1;
    #1;
    compare("async_rst_pend",  bus.Pend_cnt_o,  0);
    compare("async_rst_we",    bus.RF_writeE_o, 1'b0);
    compare("async_rst_ready", bus.LU_ready_o,  1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 rst_i = 1'b0;
    sample();
    compare("post_rst_ready", bus.LU_ready_o,  1'b1);
    compare("post_rst_we",    bus.RF_writeE_o, 1'b0);
    advance();
    repeat (2) tick();

    // Starvation: one LU entry behind continuous pipeline writes
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
    tick();
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    stallCycles = 0;
    stallEdge   = -1;
    for (int j = 1; j <= 14; j++) begin
      sample();
      if (bus.Pipe_stall_o) begin
        stallCycles++;
        stallEdge = j - 1;
        compare("stall_head_rd", bus.RF_Rd_o, 5'd6);
      end
      advance();
    end
`ifdef WB_ARB_STARVE_EN
    compare("stall_cycles", stallCycles, 1);
    compare("stall_edge",   stallEdge,   STARVE_LIMIT);
`else
    compare("stall_cycles", stallCycles, 0);
`endif
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (DEPTH + 1) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
